// File: rtl/xcvr_link_sequencer.sv
// Transceiver link bring-up sequencer: reset pulse, wait for TX/RX ready, qualify PCS block lock,
// then hold the link up, retrying on timeouts or drops until the retry budget runs out.
module xcvr_link_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned READY_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE   = 64,
  parameter int unsigned LOCK_TIMEOUT  = 16384,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       force_reset,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       block_lock,
  output logic       xcvr_reset,
  output logic       link_up,
  output logic       fail,
  output logic [7:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StReset     = 3'd1,
    StWaitReady = 3'd2,
    StWaitLock  = 3'd3,
    StUp        = 3'd4,
    StFail      = 3'd5
  } state_e;

  localparam logic [15:0] ResetLast  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] ReadyLast  = 16'(READY_TIMEOUT - 1);
  localparam logic [15:0] StableLast = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] LockLast   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  MaxRetries = 8'(MAX_RETRIES);

  logic [2:0] meta_q, sync_q;
  logic       run_q;
  logic       tx_s, rx_s, lock_s;

  // run_q holds the FSM off until the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
      run_q  <= 1'b0;
    end else begin
      meta_q <= {tx_ready, rx_ready, block_lock};
      sync_q <= meta_q;
      run_q  <= 1'b1;
    end
  end

  assign tx_s   = sync_q[2];
  assign rx_s   = sync_q[1];
  assign lock_s = sync_q[0];

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        xcvr_reset_q, xcvr_reset_d;
  logic        link_up_q, link_up_d;
  logic        fail_q, fail_d;
  logic        do_retry, reenter;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 16'd1;
    lock_cnt_d = lock_cnt_q;
    retry_d    = retry_q;
    do_retry   = 1'b0;
    reenter    = 1'b0;
    if (!run_q) begin
      timer_d = timer_q;
    end else if (!enable) begin
      state_d = StIdle;
    end else if (force_reset && (state_q != StIdle)) begin
      state_d = StReset;
      retry_d = 8'd0;
      reenter = 1'b1;
    end else begin
      case (state_q)
        StIdle:      state_d = StReset;
        StReset:     if (timer_q == ResetLast) state_d = StWaitReady;
        StWaitReady: begin
          if (tx_s && rx_s)                 state_d  = StWaitLock;
          else if (timer_q == ReadyLast)    do_retry = 1'b1;
        end
        StWaitLock: begin
          if (lock_s) begin
            if (lock_cnt_q == StableLast) state_d    = StUp;
            else                          lock_cnt_d = lock_cnt_q + 16'd1;
          end else begin
            lock_cnt_d = 16'd0;
          end
          // A completed lock qualification beats a simultaneous timeout.
          if ((state_d != StUp) && (!tx_s || !rx_s || (timer_q == LockLast))) do_retry = 1'b1;
        end
        StUp:        if (!tx_s || !rx_s || !lock_s) do_retry = 1'b1;
        StFail:      state_d = StFail;
        default:     state_d = StIdle;
      endcase
      if (do_retry) begin
        if (retry_q == MaxRetries) begin
          state_d = StFail;
        end else begin
          state_d = StReset;
          if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
        end
      end
    end
    if ((state_d == StUp) && (state_q != StUp)) retry_d = 8'd0;
    if (run_q && ((state_d != state_q) || reenter)) begin
      timer_d    = 16'd0;
      lock_cnt_d = 16'd0;
    end
    xcvr_reset_d = (state_d == StIdle) || (state_d == StReset) || (state_d == StFail);
    link_up_d    = (state_d == StUp);
    fail_d       = (state_d == StFail);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      timer_q      <= 16'd0;
      lock_cnt_q   <= 16'd0;
      retry_q      <= 8'd0;
      xcvr_reset_q <= 1'b1;
      link_up_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lock_cnt_q   <= lock_cnt_d;
      retry_q      <= retry_d;
      xcvr_reset_q <= xcvr_reset_d;
      link_up_q    <= link_up_d;
      fail_q       <= fail_d;
    end
  end

  assign xcvr_reset  = xcvr_reset_q;
  assign link_up     = link_up_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_xcvr_link_sequencer.sv
// Directed bench for xcvr_link_sequencer with small timing parameters; expected values are
// hand-derived edge counts, input synchronizer latency included.
module tb_xcvr_link_sequencer;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       force_reset;
  logic       tx_ready;
  logic       rx_ready;
  logic       block_lock;
  logic       xcvr_reset;
  logic       link_up;
  logic       fail;
  logic [7:0] retry_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  xcvr_link_sequencer #(
    .RESET_CYCLES (4),
    .READY_TIMEOUT(20),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (50),
    .MAX_RETRIES  (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .force_reset(force_reset),
    .tx_ready   (tx_ready),
    .rx_ready   (rx_ready),
    .block_lock (block_lock),
    .xcvr_reset (xcvr_reset),
    .link_up    (link_up),
    .fail       (fail),
    .retry_count(retry_count),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic xr,
                         input logic lu, input logic fl, input logic [7:0] rc);
    chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
    chk({tag, ".xcvr_reset"}, {7'd0, xcvr_reset}, {7'd0, xr});
    chk({tag, ".link_up"}, {7'd0, link_up}, {7'd0, lu});
    chk({tag, ".fail"}, {7'd0, fail}, {7'd0, fl});
    chk({tag, ".retry_count"}, retry_count, rc);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    force_reset = 1'b0;
    tx_ready    = 1'b1;
    rx_ready    = 1'b1;
    block_lock  = 1'b1;
    #12;
    chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);

    // Nominal bring-up; edges counted from reset release (E1 at t=15).
    reset_n = 1'b1;
    tick(1);
    chk_all("e1_idle", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("e2_reset", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(3);
    chk_all("e5_reset_last", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("e6_wait_ready", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("e7_wait_lock", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(7);
    chk_all("e14_still_lock", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("e15_up", 3'd4, 1'b0, 1'b1, 1'b0, 8'd0);

    // Link drop in UP: two sync stages, then the retry edge.
    rx_ready = 1'b0;
    tick(2);
    chk_all("drop_sync_delay", 3'd4, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(1);
    chk_all("drop_retry", 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
    rx_ready = 1'b1;
    tick(4);
    chk_all("recover_wait_ready", 3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    tick(1);
    chk_all("recover_wait_lock", 3'd3, 1'b0, 1'b0, 1'b0, 8'd1);
    tick(8);
    chk_all("recover_up", 3'd4, 1'b0, 1'b1, 1'b0, 8'd0);

    // Lock glitch: 7 high, 1 low, then 8 more highs needed.
    force_reset = 1'b1;
    block_lock  = 1'b0;
    tick(1);
    chk_all("force_from_up", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    force_reset = 1'b0;
    tick(3);
    block_lock = 1'b1;
    tick(2);
    chk_all("glitch_wait_lock", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(5);
    block_lock = 1'b0;
    tick(1);
    block_lock = 1'b1;
    tick(2);
    chk_all("glitch_low_seen", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(7);
    chk_all("glitch_not_yet", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("glitch_up", 3'd4, 1'b0, 1'b1, 1'b0, 8'd0);

    // Ready never asserts: three 4+20 attempts, then FAIL.
    force_reset = 1'b1;
    tx_ready    = 1'b0;
    rx_ready    = 1'b0;
    tick(1);
    chk_all("noready_reset0", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    force_reset = 1'b0;
    tick(4);
    chk_all("noready_wait0", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(19);
    chk_all("noready_wait0_last", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("noready_retry1", 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(24);
    chk_all("noready_retry2", 3'd1, 1'b1, 1'b0, 1'b0, 8'd2);
    tick(23);
    chk_all("noready_wait2_last", 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
    tick(1);
    chk_all("noready_fail", 3'd5, 1'b1, 1'b0, 1'b1, 8'd2);
    tick(5);
    chk_all("fail_sticky", 3'd5, 1'b1, 1'b0, 1'b1, 8'd2);

    // Leaving FAIL, enable priority, then async reset in WAIT_LOCK.
    force_reset = 1'b1;
    tick(1);
    chk_all("fail_force", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    enable = 1'b0;
    tick(1);
    chk_all("enable_wins", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    force_reset = 1'b0;
    enable      = 1'b1;
    tx_ready    = 1'b1;
    rx_ready    = 1'b1;
    block_lock  = 1'b0;
    tick(1);
    chk_all("restart_reset", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(5);
    chk_all("restart_wait_lock", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    #1;
    reset_n = 1'b1;
    tick(1);
    chk_all("rerelease_e1", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("rerelease_e2", 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xcvr_link_sequencer.md
XCVR_LINK_SEQUENCER -- requirements
Module: xcvr_link_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RESET_CYCLES, 16: cycles xcvr_reset is held high per reset attempt, range 1..65535.
- READY_TIMEOUT, 4096: maximum cycles in WAIT_READY, range 1..65535.
- LOCK_STABLE, 64: consecutive cycles of block_lock high needed to declare link up, range 1..65535.
- LOCK_TIMEOUT, 16384: maximum cycles in WAIT_LOCK, range 1..65535.
- MAX_RETRIES, 7: consecutive failed attempts before FAIL, range 0..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1: single clock domain.
- reset_n, in, 1: reset, asynchronous assert, active-low.
- enable, in, 1: sequencer run enable, synchronous to clock.
- force_reset, in, 1: single-cycle request to restart the link, synchronous.
- tx_ready, in, 1: transceiver reset controller TX ready, asynchronous to clock.
- rx_ready, in, 1: transceiver reset controller RX ready, asynchronous to clock.
- block_lock, in, 1: PCS block lock, asynchronous to clock.
- xcvr_reset, out, 1: drives the transceiver reset controller reset input.
- link_up, out, 1: link is operational.
- fail, out, 1: retry budget is exhausted.
- retry_count, out, 8: consecutive failed attempts.
- state, out, 3: current state encoding.

Function
REQ-003 tx_ready, rx_ready and block_lock SHALL pass through 2-flop synchronizers, giving 2 cycles of latency; all later references mean the synchronized values.
REQ-004 The FSM SHALL have states IDLE=0, RESET=1, WAIT_READY=2, WAIT_LOCK=3, UP=4, FAIL=5; codes 6 and 7 SHALL go to IDLE.
REQ-005 xcvr_reset SHALL be 1 in IDLE, RESET and FAIL, and 0 in WAIT_READY, WAIT_LOCK and UP; all outputs SHALL be registered.
REQ-006 Priority each cycle SHALL be: enable=0 forces IDLE; otherwise force_reset, when not in IDLE, forces RESET with retry_count cleared; otherwise the normal transition applies.
REQ-007 IDLE: when enable=1, go to RESET.
REQ-008 RESET: stay for exactly RESET_CYCLES cycles, then go to WAIT_READY.
REQ-009 WAIT_READY: when tx_ready and rx_ready are both 1, go to WAIT_LOCK; when the timer reaches READY_TIMEOUT cycles first, perform a retry.
REQ-010 WAIT_LOCK: go to UP after block_lock has been 1 for LOCK_STABLE consecutive cycles, restarting the count on any 0.
REQ-011 WAIT_LOCK SHALL perform a retry on LOCK_TIMEOUT expiry or when tx_ready or rx_ready drops; lock success in the same cycle as timeout SHALL win.
REQ-012 UP: link_up=1 and retry_count cleared on entry; any of tx_ready, rx_ready or block_lock at 0 SHALL perform a retry on the next cycle.
REQ-013 Retry action: if retry_count equals MAX_RETRIES, go to FAIL; otherwise increment retry_count and go to RESET.
REQ-014 retry_count SHALL saturate at 255 and never wrap.
REQ-015 FAIL: fail=1 and xcvr_reset=1; FAIL SHALL be left only via enable=0 (to IDLE) or force_reset (to RESET, fail cleared).
REQ-016 One shared 16-bit timer SHALL reload to 0 on every state entry.
REQ-017 link_up SHALL be 1 only in UP, and fail SHALL be 1 only in FAIL.
REQ-018 The state output SHALL equal the registered FSM encoding.

Reset
REQ-019 While reset_n=0: state=IDLE, xcvr_reset=1, link_up=0, fail=0, retry_count=0, timer=0, synchronizer flops=0.
REQ-020 Reset deassertion SHALL be synchronized internally; the first transition is allowed on the second clock edge after deassertion.
REQ-021 Reset asserted mid-operation SHALL immediately return all outputs to the REQ-019 values, asynchronously.

Verification
(Parameters for all scenarios: RESET_CYCLES=4, READY_TIMEOUT=20, LOCK_STABLE=8, LOCK_TIMEOUT=50, MAX_RETRIES=2.)
REQ-022 Nominal bring-up: enable=1, ready pair high from reset, block_lock high -> xcvr_reset high 4 cycles, state 2 then 3, link_up=1 after 8 stable lock cycles, retry_count=0.
REQ-023 Ready never asserts -> three attempts of 4 reset + 20 wait cycles, retry_count steps 1, 2, then FAIL with fail=1 and xcvr_reset=1.
REQ-024 Lock glitch: block_lock high 7 cycles, low 1, then high -> link_up only after 8 further consecutive cycles, no retry.
REQ-025 Link drop in UP: rx_ready low -> within 3 cycles state=RESET, link_up=0, retry_count=1; recovery then clears retry_count to 0.
REQ-026 force_reset in FAIL -> RESET, fail=0, retry_count=0; enable=0 with force_reset=1 -> IDLE; reset_n pulse in WAIT_LOCK -> REQ-019 values.
